z_writeback: RTL and testbench
==============================

Name: z_writeback

Overview:
- Result-capture stage directly downstream of the ALU.
- Latches the 64-bit ALU result Z on the Zin strobe and keeps HI/LO architectural registers for MUL/DIV.
- Sequences the captured value onto the 32-bit internal bus: low word first, then the high word for wide ops, under a valid/ready handshake.
- Flags overrun when a new load arrives while a result is still pending.

Parameters:
DATA_W, 32, bus word width; Z input is 2*DATA_W.
OP_MUL, 5'b10000, opcode that writes HI/LO as a product.
OP_DIV, 5'b10001, opcode that writes HI=remainder and LO=quotient.

Ports:
clk  input  1  system clock, rising edge.
clr_n  input  1  asynchronous active-low reset.
z_in  input  2*DATA_W  ALU result (HI half in [63:32]).
opcode  input  5  opcode accompanying z_in.
inc_pc  input  1  ALU is in PC-increment mode; forces narrow handling.
z_load  input  1  capture strobe (Zin).
bus_data  output  DATA_W  word driven to bus.
bus_valid  output  1  bus_data is valid.
bus_sel_hi  output  1  0 = ZLO word, 1 = ZHI word.
bus_ready  input  1  bus consumer accepts the current word.
busy  output  1  state is not IDLE.
hi_out  output  DATA_W  HI register.
lo_out  output  DATA_W  LO register.
overrun  output  1  sticky: z_load was dropped while busy.
overrun_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (clr_n = 0, asynchronous) forces every register to 0 and state to IDLE:
  - outputs bus_data, bus_valid, bus_sel_hi, busy, hi_out, lo_out and overrun all = 0.
  - Reset mid-transfer abandons the pending result with no further bus_valid.
- States: IDLE, SEND_LO, SEND_HI.
- wide = (opcode == OP_MUL || opcode == OP_DIV) && !inc_pc, sampled at capture.
- IDLE with z_load = 1 at edge N:
  - zlo_q <= z_in[31:0]; zhi_q <= z_in[63:32]; wide_q <= wide.
  - If wide: lo_out <= z_in[31:0] and hi_out <= z_in[63:32] at the same edge.
  - State -> SEND_LO; bus_valid = 1 from cycle N+1 (latency 1).
- SEND_LO:
  - bus_data = zlo_q, bus_sel_hi = 0, bus_valid = 1.
  - On bus_ready: wide_q ? SEND_HI : IDLE.
- SEND_HI:
  - bus_data = zhi_q, bus_sel_hi = 1, bus_valid = 1.
  - On bus_ready -> IDLE.
- bus_valid never drops without bus_ready; bus_data and bus_sel_hi hold stable while stalled.
- bus_valid = 0 in IDLE; bus_data = 0 in IDLE.
- busy = (state != IDLE), registered from state.
- z_load while busy, including the final handshake cycle:
  - load ignored; nothing captured; hi_out/lo_out unchanged.
  - overrun <= 1.
- overrun_clr and a dropped z_load in the same cycle: set wins, overrun = 1.
- Back-to-back throughput: one narrow result per 2 cycles; one wide result per 3 cycles.
- Narrow ops never modify hi_out/lo_out; zhi_q is still captured but never driven.
- Unknown opcodes are treated as narrow; z_in is passed through as given.

Optional Feature:
Macro ZWB_FLAGS_EN.
- Defined: adds outputs flag_z and flag_n (1 bit each), registered at capture.
  - Narrow: flag_z = (z_in[31:0] == 0), flag_n = z_in[31].
  - Wide: flag_z = (z_in == 0), flag_n = z_in[63].
  - Flags hold until the next accepted capture; reset to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then ADD, z_in = 64'h0000_0000_0000_0007, z_load pulse with bus_ready = 1 -> next cycle bus_valid = 1, bus_data = 7, sel_hi = 0 -> following cycle IDLE. hi_out = lo_out = 0.
- MUL (10000), z_in = 64'h0000_0001_8000_0000, bus_ready = 1 -> lo_out = 32'h8000_0000 and hi_out = 1 after capture. Bus carries 32'h8000_0000 (sel_hi 0), then 1 (sel_hi 1), then IDLE.
- DIV, z_in = {32'd2, 32'd5}, bus_ready held 0 for 3 cycles -> bus_valid stays 1 with bus_data = 5 stable. Raise ready -> bus_data = 2, sel_hi = 1.
- Pulse z_load during SEND_HI -> overrun = 1, hi_out/lo_out unchanged. Pulse overrun_clr -> 0. Simultaneous clr and drop -> overrun stays 1.
- clr_n asserted low during SEND_LO of a MUL -> immediately bus_valid = 0, busy = 0, hi_out = lo_out = 0. No HI word after release.
- inc_pc = 1 with opcode = 10000, z_in = 64'h5_0000_0004 -> narrow: single word 4, hi_out/lo_out untouched. With ZWB_FLAGS_EN, z_in = 0 gives flag_z = 1.

Source files
------------

// File: rtl/z_writeback.sv
`default_nettype none
// ============================================================================
// Module   : z_writeback
// Purpose  : Result-capture stage behind the ALU. Latches the 2*DATA_W-bit
//            result Z on the z_load strobe and maintains the HI/LO
//            architectural registers for MUL/DIV. The captured value is then
//            put on the DATA_W-bit internal bus under a valid/ready
//            handshake: the low word always goes first, and the high word
//            follows only for wide (MUL/DIV) results. A z_load that arrives
//            while a result is still pending is dropped and sets a sticky
//            overrun flag.
//
// Ports    : clk          system clock, rising edge
//            clr_n        asynchronous active-low reset
//            z_in         ALU result (HI half in the upper DATA_W bits)
//            opcode       opcode accompanying z_in
//            inc_pc       ALU in PC-increment mode (forces narrow handling)
//            z_load       capture strobe
//            bus_data     word driven to the bus (0 when idle)
//            bus_valid    bus_data is valid
//            bus_sel_hi   0 = ZLO word, 1 = ZHI word
//            bus_ready    bus consumer accepts the current word
//            busy         stage is not IDLE
//            hi_out       HI register
//            lo_out       LO register
//            overrun      sticky: a z_load was dropped while busy
//            overrun_clr  synchronous clear of overrun
//            flag_z       (ZWB_FLAGS_EN only) zero flag of the last capture
//            flag_n       (ZWB_FLAGS_EN only) sign flag of the last capture
//
// Config   : define ZWB_FLAGS_EN to add the flag_z / flag_n outputs.
//
// Revision : 1.0 - initial release
// ============================================================================
module z_writeback #(
  parameter int         DATA_W = 32,
  parameter logic [4:0] OP_MUL = 5'b10000,
  parameter logic [4:0] OP_DIV = 5'b10001
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [2*DATA_W-1:0]   z_in,
  input  logic [4:0]            opcode,
  input  logic                  inc_pc,
  input  logic                  z_load,
  output logic [DATA_W-1:0]     bus_data,
  output logic                  bus_valid,
  output logic                  bus_sel_hi,
  input  logic                  bus_ready,
  output logic                  busy,
  output logic [DATA_W-1:0]     hi_out,
  output logic [DATA_W-1:0]     lo_out,
  output logic                  overrun,
`ifdef ZWB_FLAGS_EN
  output logic                  flag_z,
  output logic                  flag_n,
`endif
  input  logic                  overrun_clr
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEND_LO = 2'd1,
    S_SEND_HI = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   zlo_q, zhi_q;
  logic                wide_q;
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic                overrun_q, overrun_d;

  logic                capture;
  logic                drop;
  logic                wide;

  // PC-increment mode reuses the ALU adder, so it is never a wide result
  // even if the opcode field happens to decode as MUL/DIV.
  assign wide = ((opcode == OP_MUL) || (opcode == OP_DIV)) && !inc_pc;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (z_load) begin
          capture = 1'b1;
          state_d = S_SEND_LO;
        end
      end
      S_SEND_LO: begin
        if (bus_ready) begin
          state_d = wide_q ? S_SEND_HI : S_IDLE;
        end
      end
      S_SEND_HI: begin
        if (bus_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Any load outside IDLE is dropped, including the cycle whose handshake
  // would return the stage to IDLE: the capture slot is only open in IDLE.
  assign drop = z_load && (state_q != S_IDLE);

  // Setting beats clearing so a simultaneous drop is never lost.
  always_comb begin
    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= S_IDLE;
      zlo_q     <= '0;
      zhi_q     <= '0;
      wide_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      overrun_q <= overrun_d;
      if (capture) begin
        zlo_q  <= z_in[DATA_W-1:0];
        zhi_q  <= z_in[2*DATA_W-1:DATA_W];
        wide_q <= wide;
        // HI/LO are architectural state for MUL/DIV only.
        if (wide) begin
          lo_q <= z_in[DATA_W-1:0];
          hi_q <= z_in[2*DATA_W-1:DATA_W];
        end
      end
    end
  end

`ifdef ZWB_FLAGS_EN
  logic flag_z_q, flag_n_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if (capture) begin
      if (wide) begin
        flag_z_q <= (z_in == '0);
        flag_n_q <= z_in[2*DATA_W-1];
      end else begin
        flag_z_q <= (z_in[DATA_W-1:0] == '0);
        flag_n_q <= z_in[DATA_W-1];
      end
    end
  end

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
`endif

  // ---------------------------------------------------------------------
  // Outputs: all decoded from registered state, so they hold stable while
  // the consumer stalls and drop immediately on reset.
  // ---------------------------------------------------------------------
  always_comb begin
    bus_data   = '0;
    bus_sel_hi = 1'b0;
    bus_valid  = 1'b0;
    unique case (state_q)
      S_SEND_LO: begin
        bus_data  = zlo_q;
        bus_valid = 1'b1;
      end
      S_SEND_HI: begin
        bus_data   = zhi_q;
        bus_sel_hi = 1'b1;
        bus_valid  = 1'b1;
      end
      default: begin
        bus_data   = '0;
        bus_sel_hi = 1'b0;
        bus_valid  = 1'b0;
      end
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign hi_out  = hi_q;
  assign lo_out  = lo_q;
  assign overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_z_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_z_writeback
// Purpose  : Directed self-checking bench for z_writeback. Expected bus words
//            ({sel_hi, data}) are queued when a load is driven and compared
//            by a monitor whenever a valid/ready handshake completes.
//            Optional flag checks follow ZWB_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_z_writeback;

  localparam int DATA_W = 32;

  logic                clk = 1'b0;
  logic                clr_n;
  logic [2*DATA_W-1:0] z_in;
  logic [4:0]          opcode;
  logic                inc_pc;
  logic                z_load;
  logic [DATA_W-1:0]   bus_data;
  logic                bus_valid;
  logic                bus_sel_hi;
  logic                bus_ready;
  logic                busy;
  logic [DATA_W-1:0]   hi_out;
  logic [DATA_W-1:0]   lo_out;
  logic                overrun;
  logic                overrun_clr;
`ifdef ZWB_FLAGS_EN
  logic                flag_z;
  logic                flag_n;
`endif

  int checks   = 0;
  int failures = 0;
  logic [DATA_W:0] sb[$];

  always #5 clk = ~clk;

  z_writeback #(.DATA_W(DATA_W)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .z_in        (z_in),
    .opcode      (opcode),
    .inc_pc      (inc_pc),
    .z_load      (z_load),
    .bus_data    (bus_data),
    .bus_valid   (bus_valid),
    .bus_sel_hi  (bus_sel_hi),
    .bus_ready   (bus_ready),
    .busy        (busy),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .overrun     (overrun),
`ifdef ZWB_FLAGS_EN
    .flag_z      (flag_z),
    .flag_n      (flag_n),
`endif
    .overrun_clr (overrun_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every completed handshake must match the queue head.
  always @(negedge clk) begin
    if (clr_n && bus_valid && bus_ready) begin
      logic [DATA_W:0] exp_w;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $error("FAIL sb_unexpected observed=%h expected=none", {bus_sel_hi, bus_data});
      end else begin
        exp_w = sb.pop_front();
        assert ({bus_sel_hi, bus_data} === exp_w) else begin
          failures++;
          $error("FAIL sb_word observed=%h expected=%h", {bus_sel_hi, bus_data}, exp_w);
        end
      end
    end
  end

  initial begin
    clr_n       = 1'b0;
    z_in        = '0;
    opcode      = 5'b00000;
    inc_pc      = 1'b0;
    z_load      = 1'b0;
    bus_ready   = 1'b1;
    overrun_clr = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    chk("rst_valid",   bus_valid,  0);
    chk("rst_busy",    busy,       0);
    chk("rst_data",    bus_data,   0);
    chk("rst_sel",     bus_sel_hi, 0);
    chk("rst_hilo",    {hi_out, lo_out}, 0);
    chk("rst_overrun", overrun,    0);
`ifdef ZWB_FLAGS_EN
    chk("rst_flags",   {flag_z, flag_n}, 0);
`endif
    step();
    clr_n = 1'b1;
    step();

    // ---------------- narrow ADD ----------------
    z_in = 64'h0000_0000_0000_0007; opcode = 5'b00000; z_load = 1'b1;
    sb.push_back({1'b0, 32'h7});
    step();
    z_load = 1'b0;
    @(negedge clk);
    chk("add_valid", bus_valid, 1);
    chk("add_data",  bus_data,  32'h7);
    chk("add_sel",   bus_sel_hi, 0);
`ifdef ZWB_FLAGS_EN
    chk("add_flags", {flag_z, flag_n}, 2'b00);
`endif
    step();
    @(negedge clk);
    chk("add_idle",  {busy, bus_valid, bus_data}, 0);
    chk("add_hilo",  {hi_out, lo_out}, 0);

    // ---------------- wide MUL ----------------
    z_in = 64'h0000_0001_8000_0000; opcode = 5'b10000; z_load = 1'b1;
    sb.push_back({1'b0, 32'h8000_0000});
    sb.push_back({1'b1, 32'h1});
    step();
    z_load = 1'b0;
    @(negedge clk);
    chk("mul_lo",   lo_out, 32'h8000_0000);
    chk("mul_hi",   hi_out, 32'h1);
    chk("mul_w0",   {bus_valid, bus_sel_hi, bus_data}, {2'b10, 32'h8000_0000});
`ifdef ZWB_FLAGS_EN
    chk("mul_flags", {flag_z, flag_n}, 2'b00);
`endif
    step();
    @(negedge clk);
    chk("mul_w1",   {bus_valid, bus_sel_hi, bus_data}, {2'b11, 32'h1});
    step();
    @(negedge clk);
    chk("mul_idle", {busy, bus_valid}, 0);

    // ---------------- DIV with stall ----------------
    z_in = {32'd2, 32'd5}; opcode = 5'b10001; z_load = 1'b1; bus_ready = 1'b0;
    sb.push_back({1'b0, 32'd5});
    sb.push_back({1'b1, 32'd2});
    step();
    z_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("div_stall", {bus_valid, bus_sel_hi, bus_data}, {2'b10, 32'd5});
      step();
    end
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    @(negedge clk);
    chk("div_hi_word", {bus_valid, bus_sel_hi, bus_data}, {2'b11, 32'd2});
    chk("div_hilo",    {hi_out, lo_out}, {32'd2, 32'd5});

    // ---------------- overrun in SEND_HI ----------------
    z_in = 64'hDEAD_BEEF_CAFE_F00D; opcode = 5'b10000; z_load = 1'b1;
    step();
    z_load = 1'b0;
    @(negedge clk);
    chk("ovr_set",   overrun, 1);
    chk("ovr_hilo",  {hi_out, lo_out}, {32'd2, 32'd5});
    chk("ovr_hold",  {bus_valid, bus_sel_hi, bus_data}, {2'b11, 32'd2});
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    @(negedge clk);
    chk("ovr_clr",   overrun, 0);
    z_load = 1'b1; overrun_clr = 1'b1;
    step();
    z_load = 1'b0; overrun_clr = 1'b0;
    @(negedge clk);
    chk("ovr_set_wins", overrun, 1);
    chk("ovr_hilo2",    {hi_out, lo_out}, {32'd2, 32'd5});
    bus_ready = 1'b1;
    step();
    overrun_clr = 1'b1;
    @(negedge clk);
    chk("div_done", busy, 0);
    step();
    overrun_clr = 1'b0;

    // ---------------- inc_pc forces narrow; drop on final handshake ----------------
    z_in = 64'h0000_0005_0000_0004; opcode = 5'b10000; inc_pc = 1'b1; z_load = 1'b1;
    sb.push_back({1'b0, 32'h4});
    step();
    z_in = 64'h0000_0009_0000_0009; inc_pc = 1'b0;  // arrives in final handshake cycle
    @(negedge clk);
    chk("inc_word",  {bus_valid, bus_sel_hi, bus_data}, {2'b10, 32'h4});
    chk("inc_hilo",  {hi_out, lo_out}, {32'd2, 32'd5});
    step();
    z_load = 1'b0;
    @(negedge clk);
    chk("drop_idle", {busy, bus_valid}, 0);
    chk("drop_ovr",  overrun, 1);
    chk("drop_hilo", {hi_out, lo_out}, {32'd2, 32'd5});
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;

    // ---------------- unknown opcode is narrow ----------------
    z_in = 64'h1234_5678_9ABC_DEF0; opcode = 5'b11111; z_load = 1'b1;
    sb.push_back({1'b0, 32'h9ABC_DEF0});
    step();
    z_load = 1'b0;
    @(negedge clk);
    chk("unk_word",  {bus_valid, bus_sel_hi, bus_data}, {2'b10, 32'h9ABC_DEF0});
`ifdef ZWB_FLAGS_EN
    chk("unk_flags", {flag_z, flag_n}, 2'b01);
`endif
    step();
    @(negedge clk);
    chk("unk_idle",  {busy, hi_out, lo_out}, {1'b0, 32'd2, 32'd5});

`ifdef ZWB_FLAGS_EN
    // ---------------- zero flag on narrow inc_pc ----------------
    z_in = 64'h0000_0005_0000_0000; opcode = 5'b10000; inc_pc = 1'b1; z_load = 1'b1;
    sb.push_back({1'b0, 32'h0});
    step();
    z_load = 1'b0; inc_pc = 1'b0;
    @(negedge clk);
    chk("flag_zero", {flag_z, flag_n}, 2'b10);
    step();
`endif

    // ---------------- reset during SEND_LO of a MUL ----------------
    z_in = 64'h0000_0003_0000_0009; opcode = 5'b10000; z_load = 1'b1; bus_ready = 1'b0;
    step();
    z_load = 1'b0;
    @(negedge clk);
    chk("rmid_pre",  {bus_valid, lo_out, hi_out}, {1'b1, 32'd9, 32'd3});
    #1 clr_n = 1'b0;
    #1;
    chk("rmid_valid", bus_valid, 0);
    chk("rmid_busy",  busy, 0);
    chk("rmid_hilo",  {hi_out, lo_out}, 0);
    step();
    clr_n = 1'b1; bus_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rmid_no_hi", {bus_valid, busy}, 0);
      step();
    end

    chk("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
